// File: rtl/datapath_pkg.sv
// Shared widths and ALU opcode encodings for the datapath and its ALU.
package datapath_pkg;

  localparam int WORD_W  = 32;
  localparam int DWORD_W = 64;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: a comes from Y, b from the bus; 64-bit result for MUL/DIV.
module alu
  import datapath_pkg::*;
(
  input  logic [WORD_W-1:0]  a,
  input  logic [WORD_W-1:0]  b,
  input  logic [4:0]         opcode,
  output logic [DWORD_W-1:0] result
);

  logic [4:0]                sh;
  logic [WORD_W-1:0]         lo;
  logic signed [DWORD_W-1:0] a_ext, b_ext;
  logic signed [WORD_W-1:0]  quot, rem;

  assign sh    = b[4:0];
  assign a_ext = {{WORD_W{a[WORD_W-1]}}, a};
  assign b_ext = {{WORD_W{b[WORD_W-1]}}, b};

  always_comb begin
    lo     = '0;
    quot   = '0;
    rem    = '0;
    result = '0;
    case (opcode)
      OP_ADD:  lo = a + b;
      OP_SUB:  lo = a - b;
      OP_AND:  lo = a & b;
      OP_OR:   lo = a | b;
      OP_SHR:  lo = a >> sh;
      OP_SHRA: lo = $signed(a) >>> sh;
      OP_SHL:  lo = a << sh;
      OP_ROR:  lo = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
      OP_ROL:  lo = (a << sh) | (a >> (6'd32 - {1'b0, sh}));
      OP_NEG:  lo = '0 - b;
      OP_NOT:  lo = ~b;
      default: lo = '0;
    endcase
    result = {{WORD_W{1'b0}}, lo};
    if (opcode == OP_MUL) begin
      result = a_ext * b_ext;
    end else if (opcode == OP_DIV) begin
      // Divide by zero leaves both quotient and remainder at zero.
      if (b != '0) begin
        quot = $signed(a) / $signed(b);
        rem  = $signed(a) % $signed(b);
      end
      result = {rem, quot};
    end
  end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, special registers, bus mux and Z capture of the ALU.
module datapath
  import datapath_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic HIin, Loin, PCin, MARin, IRin, Yin,
  input  logic HIout, Loout, PCout, Yout,
  input  logic MDRin, MDRread, MDRout,
  input  logic Zin, ZHIin, ZLOin,
  input  logic ZHIout, ZHighSelect, ZLOout, ZLowSelect,
  input  logic Cout, InPortout, IncPC,
  input  logic [4:0]         ALU_opcode,
  input  logic [WORD_W-1:0]  Mdatain,
  output logic [WORD_W-1:0]  R0, R1, R2, R3, R4, R5, R6, R7,
  output logic [WORD_W-1:0]  R8, R9, R10, R11, R12, R13, R14, R15,
  output logic [WORD_W-1:0]  HI, LO, Y, IR, MAR,
  output logic [WORD_W-1:0]  ZLO, ZHI,
  output logic [DWORD_W-1:0] Z_register
);

  logic [WORD_W-1:0]  r_q [16];
  logic [WORD_W-1:0]  r_d [16];
  logic [WORD_W-1:0]  hi_q, hi_d, lo_q, lo_d, y_q, y_d, ir_q, ir_d;
  logic [WORD_W-1:0]  pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [DWORD_W-1:0] z_q, z_d;
  logic [WORD_W-1:0]  bus, c_sext;
  logic [DWORD_W-1:0] alu_r;
  logic [15:0]        r_in, r_out;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign c_sext = {{(WORD_W-19){ir_q[18]}}, ir_q[18:0]};

  // Lowest-numbered general register wins, so scan downward and let later hits override.
  always_comb begin
    bus = '0;
    if (|r_out) begin
      for (int i = 15; i >= 0; i--) begin
        if (r_out[i]) bus = r_q[i];
      end
    end
    else if (HIout)                bus = hi_q;
    else if (Loout)                bus = lo_q;
    else if (ZHIout || ZHighSelect) bus = z_q[63:32];
    else if (ZLOout || ZLowSelect)  bus = z_q[31:0];
    else if (PCout)                bus = pc_q;
    else if (MDRout)               bus = mdr_q;
    else if (InPortout)            bus = '0;
    else if (Cout)                 bus = c_sext;
    else if (Yout)                 bus = y_q;
  end

  alu u_alu (
    .a      (y_q),
    .b      (bus),
    .opcode (ALU_opcode),
    .result (alu_r)
  );

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      r_d[i] = r_in[i] ? bus : r_q[i];
    end
    hi_d  = HIin  ? bus : hi_q;
    lo_d  = Loin  ? bus : lo_q;
    y_d   = Yin   ? bus : y_q;
    ir_d  = IRin  ? bus : ir_q;
    mar_d = MARin ? bus : mar_q;
    mdr_d = MDRin ? (MDRread ? Mdatain : bus) : mdr_q;
    pc_d  = PCin ? bus : (IncPC ? pc_q + 32'd1 : pc_q);
    z_d   = z_q;
    if (Zin) begin
      z_d = alu_r;
    end else begin
      if (ZHIin) z_d[63:32] = alu_r[63:32];
      if (ZLOin) z_d[31:0]  = alu_r[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      ir_q  <= '0;
      pc_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      z_q   <= '0;
    end else begin
      r_q   <= r_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      y_q   <= y_d;
      ir_q  <= ir_d;
      pc_q  <= pc_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      z_q   <= z_d;
    end
  end

  assign R0  = r_q[0];   assign R1  = r_q[1];   assign R2  = r_q[2];   assign R3  = r_q[3];
  assign R4  = r_q[4];   assign R5  = r_q[5];   assign R6  = r_q[6];   assign R7  = r_q[7];
  assign R8  = r_q[8];   assign R9  = r_q[9];   assign R10 = r_q[10];  assign R11 = r_q[11];
  assign R12 = r_q[12];  assign R13 = r_q[13];  assign R14 = r_q[14];  assign R15 = r_q[15];
  assign HI  = hi_q;
  assign LO  = lo_q;
  assign Y   = y_q;
  assign IR  = ir_q;
  assign MAR = mar_q;
  assign ZLO = z_q[31:0];
  assign ZHI = z_q[63:32];
  assign Z_register = z_q;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed ALU vector table, corner sequences, then randomized traffic against a model.
module tb_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] rin, rout;
  logic        HIin, Loin, PCin, MARin, IRin, Yin, HIout, Loout, PCout, Yout;
  logic        MDRin, MDRread, MDRout, Zin, ZHIin, ZLOin;
  logic        ZHIout, ZHighSelect, ZLOout, ZLowSelect, Cout, InPortout, IncPC;
  logic [4:0]  ALU_opcode;
  logic [31:0] Mdatain;
  logic [31:0] rv [16];
  logic [31:0] HI, LO, Y, IR, MAR, ZLO, ZHI;
  logic [63:0] Z_register;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_y, m_ir, m_pc, m_mar, m_mdr;
  logic [63:0] m_z;

  always #5 clk = ~clk;

  datapath dut (
    .clk(clk), .clr(clr),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIin(HIin), .Loin(Loin), .PCin(PCin), .MARin(MARin), .IRin(IRin), .Yin(Yin),
    .HIout(HIout), .Loout(Loout), .PCout(PCout), .Yout(Yout),
    .MDRin(MDRin), .MDRread(MDRread), .MDRout(MDRout),
    .Zin(Zin), .ZHIin(ZHIin), .ZLOin(ZLOin),
    .ZHIout(ZHIout), .ZHighSelect(ZHighSelect), .ZLOout(ZLOout), .ZLowSelect(ZLowSelect),
    .Cout(Cout), .InPortout(InPortout), .IncPC(IncPC),
    .ALU_opcode(ALU_opcode), .Mdatain(Mdatain),
    .R0(rv[0]), .R1(rv[1]), .R2(rv[2]), .R3(rv[3]),
    .R4(rv[4]), .R5(rv[5]), .R6(rv[6]), .R7(rv[7]),
    .R8(rv[8]), .R9(rv[9]), .R10(rv[10]), .R11(rv[11]),
    .R12(rv[12]), .R13(rv[13]), .R14(rv[14]), .R15(rv[15]),
    .HI(HI), .LO(LO), .Y(Y), .IR(IR), .MAR(MAR),
    .ZLO(ZLO), .ZHI(ZHI), .Z_register(Z_register)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic idle_ctl();
    clr = 0; rin = '0; rout = '0;
    HIin = 0; Loin = 0; PCin = 0; MARin = 0; IRin = 0; Yin = 0;
    HIout = 0; Loout = 0; PCout = 0; Yout = 0;
    MDRin = 0; MDRread = 0; MDRout = 0; Zin = 0; ZHIin = 0; ZLOin = 0;
    ZHIout = 0; ZHighSelect = 0; ZLOout = 0; ZLowSelect = 0;
    Cout = 0; InPortout = 0; IncPC = 0;
    ALU_opcode = 5'd0; Mdatain = 32'd0;
  endtask

  function automatic logic [31:0] m_bus();
    for (int i = 0; i < 16; i++) if (rout[i]) return m_r[i];
    if (HIout) return m_hi;
    if (Loout) return m_lo;
    if (ZHIout || ZHighSelect) return m_z[63:32];
    if (ZLOout || ZLowSelect) return m_z[31:0];
    if (PCout) return m_pc;
    if (MDRout) return m_mdr;
    if (InPortout) return 32'd0;
    if (Cout) return {{13{m_ir[18]}}, m_ir[18:0]};
    if (Yout) return m_y;
    return 32'd0;
  endfunction

  function automatic logic [63:0] m_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    logic [63:0] aa, t;
    int sa, sb, q;
    longint p;
    s = b[4:0]; aa = {a, a}; sa = $signed(a); sb = $signed(b);
    case (op)
      5'b00000: return {32'd0, a + b};
      5'b00001: return {32'd0, a - b};
      5'b00010: return {32'd0, a & b};
      5'b00011: return {32'd0, a | b};
      5'b00100: return {32'd0, a >> s};
      5'b00101: begin q = sa >>> s; return {32'd0, q}; end
      5'b00110: return {32'd0, a << s};
      5'b00111: begin t = aa >> s; return {32'd0, t[31:0]}; end
      5'b01000: begin t = aa << s; return {32'd0, t[63:32]}; end
      5'b01001: begin p = longint'(sa) * longint'(sb); return p; end
      5'b01010: begin
        if (b == 32'd0) return 64'd0;
        q = sa / sb;
        return {sa - q * sb, q};
      end
      5'b10000: return {32'd0, 32'd0 - b};
      5'b10001: return {32'd0, ~b};
      default:  return 64'd0;
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 16; i++) chk($sformatf("R%0d", i), rv[i], m_r[i]);
    chk("HI", HI, m_hi);   chk("LO", LO, m_lo);   chk("Y", Y, m_y);
    chk("IR", IR, m_ir);   chk("MAR", MAR, m_mar);
    chk("ZLO", ZLO, m_z[31:0]); chk("ZHI", ZHI, m_z[63:32]);
    chk("Z_register", Z_register, m_z);
  endtask

  // Advance the model by one cycle from the current controls, clock the DUT, compare, then idle.
  task automatic tick();
    logic [31:0] b;
    logic [63:0] r;
    b = m_bus();
    r = m_alu(ALU_opcode, m_y, b);
    if (clr) begin
      for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
      m_hi = 0; m_lo = 0; m_y = 0; m_ir = 0; m_pc = 0; m_mar = 0; m_mdr = 0; m_z = 0;
    end else begin
      for (int i = 0; i < 16; i++) if (rin[i]) m_r[i] = b;
      if (HIin)  m_hi  = b;
      if (Loin)  m_lo  = b;
      if (Yin)   m_y   = b;
      if (IRin)  m_ir  = b;
      if (MARin) m_mar = b;
      if (MDRin) m_mdr = MDRread ? Mdatain : b;
      if (PCin) m_pc = b; else if (IncPC) m_pc = m_pc + 1;
      if (Zin) m_z = r;
      else begin
        if (ZHIin) m_z[63:32] = r[63:32];
        if (ZLOin) m_z[31:0]  = r[31:0];
      end
    end
    @(posedge clk);
    #1;
    check_all();
    idle_ctl();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; MDRread = 1; MDRin = 1; tick();
  endtask

  typedef struct {
    string       nm;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vt [17];

  initial begin
    vt[0]  = '{"add",    5'b00000, 32'd5,         32'd7,         64'h0000000C};
    vt[1]  = '{"sub",    5'b00001, 32'd3,         32'd5,         64'hFFFFFFFE};
    vt[2]  = '{"and",    5'b00010, 32'h0000F0F0,  32'h0000FF00,  64'h0000F000};
    vt[3]  = '{"or",     5'b00011, 32'h0000F0F0,  32'h00000F0F,  64'h0000FFFF};
    vt[4]  = '{"shr",    5'b00100, 32'h80000000,  32'd4,         64'h08000000};
    vt[5]  = '{"shr_lo5",5'b00100, 32'h00000100,  32'h00000024,  64'h00000010};
    vt[6]  = '{"shra",   5'b00101, 32'h80000000,  32'd4,         64'hF8000000};
    vt[7]  = '{"shl",    5'b00110, 32'd1,         32'd31,        64'h80000000};
    vt[8]  = '{"ror",    5'b00111, 32'd1,         32'd1,         64'h80000000};
    vt[9]  = '{"rol",    5'b01000, 32'h80000001,  32'd4,         64'h00000018};
    vt[10] = '{"div",    5'b01010, 32'd7,         32'd2,         64'h00000001_00000003};
    vt[11] = '{"div_neg",5'b01010, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD};
    vt[12] = '{"div0",   5'b01010, 32'd7,         32'd0,         64'h0};
    vt[13] = '{"neg",    5'b10000, 32'd9,         32'd1,         64'hFFFFFFFF};
    vt[14] = '{"not",    5'b10001, 32'd9,         32'h00000012,  64'hFFFFFFED};
    vt[15] = '{"badop",  5'b01011, 32'd9,         32'd3,         64'h0};
    vt[16] = '{"mul",    5'b01001, 32'hFFFFFFFE,  32'd3,         64'hFFFFFFFF_FFFFFFFA};

    idle_ctl();
    for (int i = 0; i < 16; i++) m_r[i] = 32'hDEAD_0000;
    clr = 1; tick();
    chk("reset_R5", rv[5], 32'd0);
    chk("reset_Z", Z_register, 64'd0);

    // ALU vectors: a into Y through MDR, then b on the bus via MDR with Zin
    foreach (vt[k]) begin
      load_mdr(vt[k].a);
      MDRout = 1; Yin = 1; tick();
      load_mdr(vt[k].b);
      MDRout = 1; ALU_opcode = vt[k].op; Zin = 1; tick();
      chk({"alu_", vt[k].nm}, Z_register, vt[k].exp);
    end

    // MUL result halves routed back over the bus
    ZHIout = 1; HIin = 1; tick();
    chk("mul_hi", HI, 32'hFFFFFFFF);
    ZLowSelect = 1; Loin = 1; tick();
    chk("mul_lo", LO, 32'hFFFFFFFA);

    // Memory data into R6
    load_mdr(32'h0000000F);
    MDRout = 1; rin[6] = 1; tick();
    chk("mdr_r6", rv[6], 32'h0000000F);

    // NOT with Y loaded from R2 and operand from R1
    load_mdr(32'h4); MDRout = 1; rin[2] = 1; tick();
    load_mdr(32'h12); MDRout = 1; rin[1] = 1; tick();
    rout[2] = 1; Yin = 1; tick();
    rout[1] = 1; ALU_opcode = 5'b10001; Zin = 1; tick();
    chk("not_zlo", ZLO, 32'hFFFFFFED);
    chk("not_zhi", ZHI, 32'h0);

    // Half-Z loads
    rout[1] = 1; ALU_opcode = 5'b00000; ZHIin = 1; tick();
    chk("zhi_only", Z_register, 64'hFFFFFFED);

    // Bus priority: R1 beats R2, R2 beats HI
    rout[1] = 1; rout[2] = 1; rin[11] = 1; tick();
    chk("prio_r1", rv[11], 32'h12);
    rout[2] = 1; HIout = 1; Yout = 1; rin[12] = 1; tick();
    chk("prio_r2", rv[12], 32'h4);

    // PC wrap, then PCin over IncPC
    load_mdr(32'hFFFFFFFF); MDRout = 1; PCin = 1; tick();
    IncPC = 1; tick();
    PCout = 1; rin[7] = 1; tick();
    chk("pc_wrap", rv[7], 32'h0);
    load_mdr(32'h10); MDRout = 1; PCin = 1; IncPC = 1; tick();
    PCout = 1; rin[8] = 1; tick();
    chk("pc_prio", rv[8], 32'h10);

    // Cout sign-extends IR[18:0]
    load_mdr(32'hABC40000); MDRout = 1; IRin = 1; tick();
    Cout = 1; rin[9] = 1; tick();
    chk("cout_sext", rv[9], 32'hFFFC0000);
    InPortout = 1; Cout = 1; rin[9] = 1; tick();
    chk("inport_zero", rv[9], 32'h0);

    // clr wins over a pending R5 load
    load_mdr(32'hAA); MDRout = 1; rin[5] = 1; clr = 1; tick();
    chk("clr_r5", rv[5], 32'h0);
    chk("clr_r6", rv[6], 32'h0);
    chk("clr_hi", HI, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] b;
      for (int i = 0; i < 16; i++) begin
        rin[i]  = ($urandom_range(7) == 0);
        rout[i] = ($urandom_range(19) == 0);
      end
      HIin = $urandom_range(5) == 0;  Loin = $urandom_range(5) == 0;
      PCin = $urandom_range(5) == 0;  MARin = $urandom_range(5) == 0;
      IRin = $urandom_range(5) == 0;  Yin = $urandom_range(3) == 0;
      HIout = $urandom_range(9) == 0; Loout = $urandom_range(9) == 0;
      PCout = $urandom_range(9) == 0; Yout = $urandom_range(9) == 0;
      MDRin = $urandom_range(2) == 0; MDRread = $urandom_range(1) == 1;
      MDRout = $urandom_range(4) == 0;
      Zin = $urandom_range(2) == 0; ZHIin = $urandom_range(2) == 0; ZLOin = $urandom_range(2) == 0;
      ZHIout = $urandom_range(12) == 0; ZHighSelect = $urandom_range(12) == 0;
      ZLOout = $urandom_range(12) == 0; ZLowSelect = $urandom_range(12) == 0;
      Cout = $urandom_range(9) == 0; InPortout = $urandom_range(15) == 0;
      IncPC = $urandom_range(2) == 0;
      clr = $urandom_range(39) == 0;
      Mdatain = $urandom;
      ALU_opcode = 5'($urandom_range(31));
      b = m_bus();
      if (ALU_opcode == 5'b01010 && m_y == 32'h80000000 && b == 32'hFFFFFFFF) ALU_opcode = 5'd0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 clr  in  1  reset, synchronous, active-high.
REQ-003 R0in..R15in  in  1 each  load general register Rn from bus.
REQ-004 R0out..R15out  in  1 each  drive Rn onto bus.
REQ-005 HIin, Loin, PCin, MARin, IRin, Yin  in  1 each  load HI/LO/PC/MAR/IR/Y from bus.
REQ-006 HIout, Loout, PCout, Yout  in  1 each  drive HI/LO/PC/Y onto bus.
REQ-007 MDRin  in  1  load MDR; MDRread  in  1  MDR source select (1 = Mdatain, 0 = bus); MDRout  in  1  drive MDR onto bus.
REQ-008 Zin  in  1  load all 64 bits of Z from ALU; ZHIin, ZLOin  in  1 each  load Z[63:32] / Z[31:0] only from ALU.
REQ-009 ZHIout, ZHighSelect  in  1 each  drive Z[63:32] onto bus; ZLOout, ZLowSelect  in  1 each  drive Z[31:0] onto bus.
REQ-010 Cout  in  1  drive IR[18:0] sign-extended to 32 bits onto bus; InPortout  in  1  drive 32'h0 onto bus (in-port reserved).
REQ-011 IncPC  in  1  PC <= PC+1.
REQ-012 ALU_opcode  in  5  ALU operation select; Mdatain  in  32  memory data input.
REQ-013 R0..R15, HI, LO, Y, IR  out  32 each  current register contents.
REQ-014 ZLO, ZHI  out  32 each  Z[31:0], Z[63:32]; Z_register  out  64  full Z.

Function
REQ-015 Bus SHALL be a combinational mux; priority R0out (highest) .. R15out, HIout, Loout, ZHIout/ZHighSelect, ZLOout/ZLowSelect, PCout, MDRout, InPortout, Cout, Yout (lowest); no select -> bus = 32'h0.
REQ-016 Each register with an enable SHALL capture its source on the rising edge where enable = 1, else hold.
REQ-017 ALU SHALL be combinational, A = Y register, B = bus, 64-bit result R.
REQ-018 Opcodes: 00000 ADD, 00001 SUB (A-B), 00010 AND, 00011 OR, 00100 SHR (logical, B[4:0]), 00101 SHRA, 00110 SHL, 00111 ROR, 01000 ROL, 01001 MUL (signed, 64-bit), 01010 DIV (signed; R[31:0] = quotient, R[63:32] = remainder), 10000 NEG (0-B), 10001 NOT (~B); all others -> R = 0.
REQ-019 For non-MUL/DIV ops R[63:32] = 0 and R[31:0] = 32-bit result (wrap-around, no flags).
REQ-020 DIV by zero SHALL yield R = 64'h0.
REQ-021 Z load: Zin -> Z <= R; else ZHIin/ZLOin independently load their halves from R.
REQ-022 PC: PCin has priority over IncPC; PC+1 wraps at 32'hFFFFFFFF.
REQ-023 Simultaneous load and drive of one register SHALL drive old value and capture bus value at edge.

Reset
REQ-024 When clr = 1 at a rising edge, R0..R15, HI, LO, Y, Z, PC, MAR, MDR, IR SHALL become 0, overriding all enables.
REQ-025 clr asserted mid-operation discards any pending load that cycle.

Structure
REQ-026 Package datapath_pkg SHALL hold the 5-bit opcode constants and the 32/64-bit width parameters.
REQ-027 ALU SHALL be a separate sub-module alu (Y, bus, opcode -> 64-bit result); registers and bus mux stay in datapath.

Verification
REQ-028 Mdatain = 0x0000000F, MDRread=1, MDRin=1 one cycle; then MDRout=1, R6in=1 -> R6 = 0x0000000F.
REQ-029 NOT: R2 = 0x00000004 -> Y via R2out/Yin; R1out=1, opcode 10001, Zin=1 with R1 = 0x00000012 -> ZLO = 0xFFFFFFED, ZHI = 0.
REQ-030 MUL: Y = 0xFFFFFFFE (-2), bus = 3, Zin -> Z_register = 0xFFFFFFFF_FFFFFFFA; ZHIout then HIin -> HI = 0xFFFFFFFF.
REQ-031 DIV: Y = 7, bus = 2 -> ZLO = 3, ZHI = 1; bus = 0 -> Z = 0.
REQ-032 PC = 0xFFFFFFFF, IncPC=1 -> PC = 0; PCin=1 and IncPC=1 with bus = 0x10 -> PC = 0x10.
REQ-033 clr=1 with R5in=1 and bus = 0xAA -> all registers 0, R5 = 0.
